// File: rtl/sipo_deser.sv
// MSB-first serial-to-parallel deserializer with a one-entry valid/ready holding register.
// Define SIPO_ONES_COUNT_EN to add the ones_count popcount output alongside parallel_out.
module sipo_deser #(
    parameter  int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             shift_en,
    input  logic             serial_in,
    input  logic             out_ready,
    input  logic             clr_overflow,
    output logic [WIDTH-1:0] parallel_out,
    output logic             out_valid,
    output logic             overflow,
`ifdef SIPO_ONES_COUNT_EN
    output logic [CNT_W-1:0] ones_count,
`endif
    output logic             busy
);

    // state   | meaning
    // IDLE    | no partial word, bit count = 0
    // COLLECT | partial word in progress, 0 < count < WIDTH
    typedef enum logic {IDLE, COLLECT} state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    state_t           state, state_n;
    logic [WIDTH-1:0] shift_reg, shift_n, shift_base, sampled;
    logic [CNT_W-1:0] count, count_n, count_base;
    logic [WIDTH-1:0] hold_n;
    logic             valid_n, overflow_n;
    logic             complete, load, drop;

    // frame_start realigns first, so a bit sampled in the same cycle becomes bit 0.
    always_comb begin
        shift_base = frame_start ? '0 : shift_reg;
        count_base = frame_start ? '0 : count;
        sampled    = {shift_base[WIDTH-2:0], serial_in};
        complete   = shift_en && (count_base == LAST_IDX);
        load       = complete && (!out_valid || out_ready);
        drop       = complete && out_valid && !out_ready;

        shift_n = shift_base;
        count_n = count_base;
        if (shift_en) begin
            if (complete) begin
                shift_n = '0;
                count_n = '0;
            end else begin
                shift_n = sampled;
                count_n = count_base + CNT_W'(1);
            end
        end
        state_n = (count_n != '0) ? COLLECT : IDLE;

        hold_n  = parallel_out;
        valid_n = out_valid;
        if (load) begin
            hold_n  = sampled;
            valid_n = 1'b1;
        end else if (out_valid && out_ready) begin
            valid_n = 1'b0;
        end
        overflow_n = (overflow && !clr_overflow) || drop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            shift_reg    <= '0;
            count        <= '0;
            parallel_out <= '0;
            out_valid    <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            state        <= state_n;
            shift_reg    <= shift_n;
            count        <= count_n;
            parallel_out <= hold_n;
            out_valid    <= valid_n;
            overflow     <= overflow_n;
        end
    end

    assign busy = (state == COLLECT);

`ifdef SIPO_ONES_COUNT_EN
    logic [CNT_W-1:0] acc, acc_base, acc_sum;

    always_comb begin
        acc_base = frame_start ? '0 : acc;
        acc_sum  = acc_base + CNT_W'(serial_in);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            ones_count <= '0;
        end else begin
            if (shift_en) begin
                acc <= complete ? '0 : acc_sum;
            end else begin
                acc <= acc_base;
            end
            if (load) begin
                ones_count <= acc_sum;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sipo_deser.sv
// Scoreboard bench for sipo_deser (WIDTH=4): stimulus pushes expected words, a monitor pops them on transfers.
module tb_sipo_deser;

    logic       clk = 1'b0;
    logic       rst, frame_start, shift_en, serial_in, out_ready, clr_overflow;
    logic [3:0] parallel_out;
    logic       out_valid, overflow, busy;
`ifdef SIPO_ONES_COUNT_EN
    logic [2:0] ones_count;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] word;
        logic [2:0] ones;
    } exp_t;

    exp_t sb[$];
    exp_t got;

    sipo_deser #(.WIDTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_start  (frame_start),
        .shift_en     (shift_en),
        .serial_in    (serial_in),
        .out_ready    (out_ready),
        .clr_overflow (clr_overflow),
        .parallel_out (parallel_out),
        .out_valid    (out_valid),
        .overflow     (overflow),
`ifdef SIPO_ONES_COUNT_EN
        .ones_count   (ones_count),
`endif
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bit_in(input logic b);
        shift_en  = 1'b1;
        serial_in = b;
        tick();
        shift_en  = 1'b0;
    endtask

    task automatic expect_word(input logic [3:0] w, input logic [2:0] n);
        exp_t e;
        e.word = w;
        e.ones = n;
        sb.push_back(e);
    endtask

    // Monitor: every accepted word must match the next scoreboard entry.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual=%0h required=none @%0t", parallel_out, $time);
            end else begin
                got = sb.pop_front();
                chk("sb_word", 32'(parallel_out), 32'(got.word));
`ifdef SIPO_ONES_COUNT_EN
                chk("sb_ones", 32'(ones_count), 32'(got.ones));
`endif
            end
        end
    end

    initial begin
        rst = 1'b1; frame_start = 1'b0; shift_en = 1'b0; serial_in = 1'b0;
        out_ready = 1'b0; clr_overflow = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        chk("rst_data", 32'(parallel_out), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_busy", 32'(busy), 0);
`ifdef SIPO_ONES_COUNT_EN
        chk("rst_ones", 32'(ones_count), 0);
`endif

        // 1: basic word 1011, single-cycle valid
        out_ready = 1'b1;
        expect_word(4'b1011, 3'd3);
        bit_in(1); bit_in(0); bit_in(1);
        chk("t1_valid_early", 32'(out_valid), 0);
        bit_in(1);
        chk("t1_valid", 32'(out_valid), 1);
        chk("t1_busy_done", 32'(busy), 0);
        tick();
        chk("t1_valid_drop", 32'(out_valid), 0);

        // 2: 0110 with idle gaps, busy spans the word
        expect_word(4'b0110, 3'd2);
        bit_in(0);
        chk("t2_busy_b1", 32'(busy), 1);
        tick();
        chk("t2_busy_gap1", 32'(busy), 1);
        bit_in(1);
        repeat (3) tick();
        chk("t2_busy_gap3", 32'(busy), 1);
        bit_in(1);
        bit_in(0);
        chk("t2_valid", 32'(out_valid), 1);
        chk("t2_busy_end", 32'(busy), 0);
        tick();

        // 3: realign mid-word; partial 11 discarded
        expect_word(4'b0011, 3'd2);
        bit_in(1); bit_in(1);
        frame_start = 1'b1;
        bit_in(0);
        frame_start = 1'b0;
        chk("t3_busy_realign", 32'(busy), 1);
        chk("t3_valid_none", 32'(out_valid), 0);
        bit_in(0); bit_in(1);
        chk("t3_valid_pre", 32'(out_valid), 0);
        bit_in(1);
        chk("t3_valid", 32'(out_valid), 1);
        chk("t3_ovf", 32'(overflow), 0);
        tick();

        // 4: backpressure overflow, drain, clear
        out_ready = 1'b0;
        expect_word(4'b1100, 3'd2);
        bit_in(1); bit_in(1); bit_in(0); bit_in(0);
        chk("t4_valid1", 32'(out_valid), 1);
        chk("t4_data1", 32'(parallel_out), 32'hC);
        chk("t4_ovf_pre", 32'(overflow), 0);
        bit_in(0); bit_in(1); bit_in(0); bit_in(1);
        chk("t4_ovf", 32'(overflow), 1);
        chk("t4_valid_hold", 32'(out_valid), 1);
        chk("t4_data_hold", 32'(parallel_out), 32'hC);
        out_ready = 1'b1;
        tick();
        chk("t4_valid_drained", 32'(out_valid), 0);
        chk("t4_ovf_sticky", 32'(overflow), 1);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        chk("t4_ovf_clr", 32'(overflow), 0);

        // 5: back-to-back words 1001, 0110
        expect_word(4'b1001, 3'd2);
        expect_word(4'b0110, 3'd2);
        bit_in(1); bit_in(0); bit_in(0); bit_in(1);
        chk("t5_valid_w1", 32'(out_valid), 1);
        chk("t5_busy_w1", 32'(busy), 0);
        bit_in(0);
        chk("t5_valid_gap", 32'(out_valid), 0);
        bit_in(1); bit_in(1); bit_in(0);
        chk("t5_valid_w2", 32'(out_valid), 1);
        tick();
        chk("t5_valid_end", 32'(out_valid), 0);
        chk("t5_ovf", 32'(overflow), 0);

        // 6: reset mid-word with a pending word, then clean 1111
        out_ready = 1'b0;
        bit_in(1); bit_in(0); bit_in(1); bit_in(0);
        chk("t6_pending", 32'(out_valid), 1);
        bit_in(1); bit_in(1); bit_in(0);
        chk("t6_busy_pre", 32'(busy), 1);
        rst = 1'b1;
        bit_in(1);
        rst = 1'b0;
        chk("t6_rst_data", 32'(parallel_out), 0);
        chk("t6_rst_valid", 32'(out_valid), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_ovf", 32'(overflow), 0);
`ifdef SIPO_ONES_COUNT_EN
        chk("t6_rst_ones", 32'(ones_count), 0);
`endif
        out_ready = 1'b1;
        expect_word(4'b1111, 3'd4);
        bit_in(1); bit_in(1); bit_in(1); bit_in(1);
        chk("t6_valid", 32'(out_valid), 1);
        tick();
        tick();
        chk("sb_drained", 32'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
